// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore control FSM for one game round (prepare, wait play, register, compare, advance, finish).
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    inicial       = 4'b0000,
    preparacao    = 4'b0001,
    espera_jogada = 4'b0010,
    registra      = 4'b0100,
    comparacao    = 4'b0101,
    proximo       = 4'b0110,
    fim_acerto    = 4'b1010,
    fim_timeout   = 4'b1101,
    fim_erro      = 4'b1110
  } estado_t;
  localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);
  estado_t     estado, prox;
  logic [15:0] cnt;
  always_comb begin
    prox = inicial;
    case (estado)
      inicial:                             prox = iniciar ? preparacao : inicial;
      preparacao:                          prox = espera_jogada;
      espera_jogada:                       prox = jogada ? registra : (cnt == LIMITE ? fim_timeout : espera_jogada);
      registra:                            prox = comparacao;
      comparacao:                          prox = !igual ? fim_erro : (fim ? fim_acerto : proximo);
      proximo:                             prox = espera_jogada;
      fim_acerto, fim_erro, fim_timeout:   prox = iniciar ? preparacao : estado;
      default:                             prox = inicial;
    endcase
  end
  // Outputs are registered from the next state, so they always match the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= inicial;
      cnt       <= '0;
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      estado    <= prox;
      cnt       <= (estado == espera_jogada && prox == espera_jogada) ? cnt + 16'd1 : '0;
      zeraC     <= prox == preparacao;
      contaC    <= prox == proximo;
      zeraR     <= prox == preparacao;
      registraR <= prox == registra;
      acertou   <= prox == fim_acerto;
      errou     <= prox == fim_erro;
      timeout   <= prox == fim_timeout;
      pronto    <= prox inside {fim_acerto, fim_erro, fim_timeout};
    end
  end
  assign db_estado = estado;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: directed scoreboard bench for the game control FSM.
module tb_unidade_controle_jogo;
  localparam logic [3:0] S_INI = 4'b0000, S_PREP = 4'b0001, S_ESP = 4'b0010, S_REG = 4'b0100,
                         S_CMP = 4'b0101, S_PROX = 4'b0110, S_ACE = 4'b1010, S_TMO = 4'b1101,
                         S_ERR = 4'b1110;
  logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fim = 1'b0;
  logic zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto;
  logic [3:0] db_estado;
  int tests = 0, fails = 0, zc_cnt = 0, cc_cnt = 0;
  typedef struct { logic [3:0] st; string tag; } exp_t;
  exp_t q[$];

  unidade_controle_jogo #(.TIMEOUT_CICLOS(10)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual), .fim(fim),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR), .acertou(acertou),
    .errou(errou), .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  // {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto} expected in each state
  function automatic logic [7:0] exp_out(input logic [3:0] s);
    case (s)
      S_PREP:  return 8'b1010_0000;
      S_REG:   return 8'b0001_0000;
      S_PROX:  return 8'b0100_0000;
      S_ACE:   return 8'b0000_1001;
      S_ERR:   return 8'b0000_0101;
      S_TMO:   return 8'b0000_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] obs_out();
    return {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto};
  endfunction

  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard: queue empty, required one pending expectation");
      return;
    end
    e = q.pop_front();
    tests++;
    assert (db_estado === e.st) else begin
      fails++;
      $error("FAIL %s state: got %b, required %b", e.tag, db_estado, e.st);
    end
    tests++;
    assert (obs_out() === exp_out(e.st)) else begin
      fails++;
      $error("FAIL %s outputs: got %b, required %b", e.tag, obs_out(), exp_out(e.st));
    end
  endtask

  task automatic cyc(input logic ini, input logic jog, input logic ig, input logic fm,
                     input logic [3:0] st, input string tag);
    iniciar = ini; jogada = jog; igual = ig; fim = fm;
    q.push_back('{st, tag});
    @(posedge clock);
    #1;
    check();
    zc_cnt += int'(zeraC);
    cc_cnt += int'(contaC);
  endtask

  // one play: jogada pulse, then compare result on the verdict edge, then back to wait if advancing
  task automatic play(input logic ig, input logic fm, input logic [3:0] verdict, input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_REG, {tag, "_reg"});
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_CMP, {tag, "_cmp"});
    cyc(1'b0, 1'b0, ig, fm, verdict, {tag, "_verdict"});
    if (verdict == S_PROX) cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, {tag, "_back"});
  endtask

  task automatic count_check(input int got, input int req, input string tag);
    tests++;
    assert (got == req) else begin
      fails++;
      $error("FAIL %s: got %0d pulses, required %0d", tag, got, req);
    end
  endtask

  initial begin
    #3;
    q.push_back('{S_INI, "reset_async"});
    check();
    @(posedge clock); #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_INI, "idle");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, S_INI, "idle_jogada_ignored");
    // round won: iniciar held 5 cycles, 4 plays, fim on the 4th
    zc_cnt = 0; cc_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_PREP, "start");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, S_ESP, "iniciar_held");
    for (int i = 0; i < 3; i++) play(1'b1, 1'b0, S_PROX, "win_play");
    play(1'b1, 1'b1, S_ACE, "win_last");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ACE, "acerto_hold");
    count_check(zc_cnt, 1, "win_zeraC_count");
    count_check(cc_cnt, 3, "win_contaC_count");
    // round lost on the 5th play
    zc_cnt = 0; cc_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_PREP, "restart_from_acerto");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, "wait");
    for (int i = 0; i < 4; i++) play(1'b1, 1'b0, S_PROX, "lose_ok");
    play(1'b0, 1'b1, S_ERR, "lose_bad");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ERR, "erro_hold");
    count_check(cc_cnt, 4, "lose_contaC_count");
    // restart from fim_erro
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_PREP, "restart_from_erro");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, "flags_cleared");
    // timeout after exactly 10 cycles in espera_jogada
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, "tmo_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_TMO, "tmo_expire");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_TMO, "tmo_hold");
    // jogada in the 10th cycle wins over timeout
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_PREP, "restart_from_tmo");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, "wait2");
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, "tmo2_wait");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_REG, "jogada_beats_tmo");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_CMP, "in_comparacao");
    // asynchronous reset pulse between edges while in comparacao
    #2;
    reset = 1'b1;
    #1;
    q.push_back('{S_INI, "reset_mid_round"});
    check();
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    q.push_back('{S_INI, "after_reset_edge"});
    check();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, S_INI, "wait_for_iniciar");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_PREP, "start_after_reset");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_ESP, "wait3");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
